// File: rtl/system_manager_cpu_mult_sched.sv
// Two-requester round-robin scheduler driving an external registered 16x16 partial-product mult cell.
// Optional build macro MULT_SCHED_HI_EN: adds ISSUE2/CAP2 so rX_hi requests also get the high product word.
module system_manager_cpu_mult_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic        r0_hi,
    input  logic        r1_hi,
    output logic [31:0] E_src1,
    output logic [31:0] E_src2,
    output logic        M_en,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [31:0] res_lo,
    output logic [31:0] res_hi
);

    localparam int unsigned W  = 32;
    localparam int unsigned HW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        CAP    = 3'd2,
`ifdef MULT_SCHED_HI_EN
        ISSUE2 = 3'd3,
        CAP2   = 3'd4,
`endif
        DONE   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           id_q, id_d;
    logic [W-1:0]   e_src1_q, e_src1_d;
    logic [W-1:0]   e_src2_q, e_src2_d;
    logic [W-1:0]   res_lo_q, res_lo_d;

    logic           sel_c;
    logic [W:0]     x_c;
    logic [W:0]     lo_sum_c;

`ifdef MULT_SCHED_HI_EN
    logic           hi_q, hi_d;
    logic [HW-1:0]  a_hi_q, a_hi_d;
    logic [HW-1:0]  b_hi_q, b_hi_d;
    logic [W-HW:0]  xh_q, xh_d;
    logic           c_q, c_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic [W-1:0]   hi_sum_c;
`else
    logic           unused_c;
`endif

    // Round-robin grant, only in IDLE and never while reset is asserted
    assign r0_ready = reset_n & (state_q == IDLE) & r0_valid & (last_q | ~r1_valid);
    assign r1_ready = reset_n & (state_q == IDLE) & r1_valid & (~last_q | ~r0_valid);
    assign sel_c    = r1_ready;

    // Cross-term sum and low-word add; the carry feeds the high word
    assign x_c      = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
    assign lo_sum_c = {1'b0, M_mul_cell_p1} + {1'b0, x_c[HW-1:0], HW'(0)};

`ifdef MULT_SCHED_HI_EN
    assign hi_sum_c = M_mul_cell_p1 + W'(xh_q) + W'(c_q);
    assign res_hi   = res_hi_q;
    assign M_en     = (state_q == ISSUE) || (state_q == ISSUE2);
`else
    assign unused_c = ^{r0_hi, r1_hi, x_c[W:HW], lo_sum_c[W]};
    assign res_hi   = '0;
    assign M_en     = (state_q == ISSUE);
`endif

    assign E_src1    = e_src1_q;
    assign E_src2    = e_src2_q;
    assign res_valid = (state_q == DONE);
    assign res_id    = id_q;
    assign res_lo    = res_lo_q;

    // Next-state and datapath load decisions
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        e_src1_d = e_src1_q;
        e_src2_d = e_src2_q;
        res_lo_d = res_lo_q;
`ifdef MULT_SCHED_HI_EN
        hi_d     = hi_q;
        a_hi_d   = a_hi_q;
        b_hi_d   = b_hi_q;
        xh_d     = xh_q;
        c_d      = c_q;
        res_hi_d = res_hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (r0_ready || r1_ready) begin
                    id_d     = sel_c;
                    last_d   = sel_c;
                    e_src1_d = sel_c ? r1_a : r0_a;
                    e_src2_d = sel_c ? r1_b : r0_b;
`ifdef MULT_SCHED_HI_EN
                    hi_d     = sel_c ? r1_hi : r0_hi;
                    a_hi_d   = sel_c ? r1_a[W-1:HW] : r0_a[W-1:HW];
                    b_hi_d   = sel_c ? r1_b[W-1:HW] : r0_b[W-1:HW];
                    res_hi_d = '0;
`endif
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAP;
            end
            CAP: begin
                res_lo_d = lo_sum_c[W-1:0];
`ifdef MULT_SCHED_HI_EN
                xh_d = x_c[W:HW];
                c_d  = lo_sum_c[W];
                if (hi_q) begin
                    e_src1_d = {HW'(0), a_hi_q};
                    e_src2_d = {HW'(0), b_hi_q};
                    state_d  = ISSUE2;
                end else begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end
`ifdef MULT_SCHED_HI_EN
            ISSUE2: begin
                state_d = CAP2;
            end
            CAP2: begin
                res_hi_d = hi_sum_c;
                state_d  = DONE;
            end
`endif
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Operand, result and cross-term registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q     <= 1'b0;
            e_src1_q <= '0;
            e_src2_q <= '0;
            res_lo_q <= '0;
`ifdef MULT_SCHED_HI_EN
            hi_q     <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            xh_q     <= '0;
            c_q      <= 1'b0;
            res_hi_q <= '0;
`endif
        end else begin
            id_q     <= id_d;
            e_src1_q <= e_src1_d;
            e_src2_q <= e_src2_d;
            res_lo_q <= res_lo_d;
`ifdef MULT_SCHED_HI_EN
            hi_q     <= hi_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            xh_q     <= xh_d;
            c_q      <= c_d;
            res_hi_q <= res_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_system_manager_cpu_mult_sched.sv
// Bench for system_manager_cpu_mult_sched: mult-cell model plus a result scoreboard.
// Works with and without MULT_SCHED_HI_EN.
module tb_system_manager_cpu_mult_sched;

`ifdef MULT_SCHED_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    localparam int MAX_WAIT = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_hi, r1_hi;
    logic [31:0] E_src1, E_src2;
    logic        M_en;
    logic [31:0] cell_p1 = 32'h0, cell_p2 = 32'h0, cell_p3 = 32'h0;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_lo, res_hi;

    typedef struct {
        logic        id;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          men;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    system_manager_cpu_mult_sched dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_hi(r0_hi), .r1_hi(r1_hi),
        .E_src1(E_src1), .E_src2(E_src2), .M_en(M_en),
        .M_mul_cell_p1(cell_p1), .M_mul_cell_p2(cell_p2), .M_mul_cell_p3(cell_p3),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_lo(res_lo), .res_hi(res_hi)
    );

    always #5 clk = ~clk;

    // External mult cell: partial products registered on an enabled edge
    always @(posedge clk) begin
        if (M_en) begin
            cell_p1 <= 32'(E_src1[15:0])  * 32'(E_src2[15:0]);
            cell_p2 <= 32'(E_src1[15:0])  * 32'(E_src2[31:16]);
            cell_p3 <= 32'(E_src1[31:16]) * 32'(E_src2[15:0]);
        end
    end

    function automatic exp_t expect_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                                       input logic hi);
        exp_t        e;
        logic [63:0] prod;
        prod  = {32'h0, a} * {32'h0, b};
        e.id  = id;
        e.lo  = prod[31:0];
        e.hi  = (HI_EN && hi) ? prod[63:32] : 32'h0;
        e.lat = (HI_EN && hi) ? 5 : 3;
        e.men = (HI_EN && hi) ? 2 : 1;
        return e;
    endfunction

    task automatic drive_req(input logic id, input logic [31:0] a, input logic [31:0] b, input logic hi);
        if (id) begin
            r1_valid = 1'b1; r1_a = a; r1_b = b; r1_hi = hi;
        end else begin
            r0_valid = 1'b1; r0_a = a; r0_b = b; r0_hi = hi;
        end
    endtask

    task automatic clear_req();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    // Follows an accepted op until res_valid; lat stays 0 if it never arrives
    task automatic wait_res(output int lat, output int men, output logic [31:0] e1k1, output logic [31:0] e2k1,
                            output logic [31:0] e1k3);
        lat = 0; men = 0; e1k1 = '0; e2k1 = '0; e1k3 = '0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            if (k == 1) begin e1k1 = E_src1; e2k1 = E_src2; end
            if (k == 3) e1k3 = E_src1;
            if (M_en) men++;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_req(1'b0, 32'd1, 32'd1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({res_valid, M_en, r0_ready, r1_ready, res_id} !== 5'b0 || res_lo !== 0 || res_hi !== 0 ||
            E_src1 !== 0 || E_src2 !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b men=%b rdy=%b%b id=%b lo=%h hi=%h s1=%h s2=%h required all zero",
                     res_valid, M_en, r0_ready, r1_ready, res_id, res_lo, res_hi, E_src1, E_src2);
        end
        clear_req();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3;
        @(negedge clk);
        drive_req(1'b0, 32'd3, 32'd5, 1'b0);
        #1;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL basic_ready: got %b%b required 10", r0_ready, r1_ready);
        end
        sb.push_back(expect_op(1'b0, 32'd3, 32'd5, 1'b0));
        @(posedge clk); #1; clear_req();
        wait_res(lat, men, s1, s2, s3);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d required 3", lat); end
        checks++;
        if (men !== 1) begin errors++; $display("FAIL basic_men_cycles: got %0d required 1", men); end
        checks++;
        if (s1 !== 32'd3 || s2 !== 32'd5) begin
            errors++; $display("FAIL basic_esrc: got %h %h required 3 5", s1, s2);
        end
        e = sb.pop_front();
        checks++;
        if ({res_id, res_lo, res_hi} !== {e.id, e.lo, e.hi}) begin
            errors++; $display("FAIL basic_result: got id=%b lo=%h hi=%h required id=%b lo=%h hi=%h",
                               res_id, res_lo, res_hi, e.id, e.lo, e.hi);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_release: got %b required 0", res_valid); end
    endtask

    task automatic test_hi_word();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3, e3;
        @(negedge clk);
        drive_req(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        e = expect_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        sb.push_back(e);
        @(posedge clk); #1; clear_req();
        wait_res(lat, men, s1, s2, s3);
        e3 = HI_EN ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL hi_latency: got %0d required %0d", lat, e.lat); end
        checks++;
        if (men !== e.men) begin errors++; $display("FAIL hi_men_cycles: got %0d required %0d", men, e.men); end
        checks++;
        if (s3 !== e3) begin errors++; $display("FAIL hi_esrc_cycle3: got %h required %h", s3, e3); end
        e = sb.pop_front();
        checks++;
        if ({res_id, res_lo, res_hi} !== {e.id, e.lo, e.hi}) begin
            errors++; $display("FAIL hi_result: got id=%b lo=%h hi=%h required id=%b lo=%h hi=%h",
                               res_id, res_lo, res_hi, e.id, e.lo, e.hi);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3, a, b; logic hi;
        for (int i = 0; i < 8; i++) begin
            a  = (i == 0) ? 32'h0 : $urandom;
            b  = (i == 1) ? 32'hFFFF_FFFF : $urandom;
            hi = 1'($urandom_range(0, 1));
            @(negedge clk);
            drive_req(1'(i), a, b, hi);
            sb.push_back(expect_op(1'(i), a, b, hi));
            @(posedge clk); #1; clear_req();
            wait_res(lat, men, s1, s2, s3);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || s1 !== a || s2 !== b) begin
                errors++; $display("FAIL rand%0d_issue: got lat=%0d s1=%h s2=%h required lat=%0d s1=%h s2=%h",
                                   i, lat, s1, s2, e.lat, a, b);
            end
            checks++;
            if ({res_id, res_lo, res_hi} !== {e.id, e.lo, e.hi}) begin
                errors++; $display("FAIL rand%0d_result: got id=%b lo=%h hi=%h required id=%b lo=%h hi=%h",
                                   i, res_id, res_lo, res_hi, e.id, e.lo, e.hi);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3; logic want;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        drive_req(1'b0, 32'd11, 32'd13, 1'b0);
        drive_req(1'b1, 32'd1000, 32'd7, 1'b0);
        for (int op = 0; op < 4; op++) begin
            if (op != 0) @(negedge clk);
            #1;
            want = 1'(op);
            checks++;
            if (r0_ready !== ~want || r1_ready !== want) begin
                errors++; $display("FAIL grant%0d: got rdy=%b%b required id %0d", op, r0_ready, r1_ready, want);
            end
            sb.push_back(want ? expect_op(1'b1, 32'd1000, 32'd7, 1'b0) : expect_op(1'b0, 32'd11, 32'd13, 1'b0));
            @(posedge clk); #1;
            wait_res(lat, men, s1, s2, s3);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || {res_id, res_lo} !== {e.id, e.lo}) begin
                errors++; $display("FAIL alt%0d_result: got lat=%0d id=%b lo=%h required lat=%0d id=%b lo=%h",
                                   op, lat, res_id, res_lo, e.lat, e.id, e.lo);
            end
            @(posedge clk);
        end
        #1; clear_req();
    endtask

    task automatic test_stall();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3; int bad;
        res_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        sb.push_back(expect_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0));
        @(posedge clk); #1; clear_req();
        wait_res(lat, men, s1, s2, s3);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL stall_latency: got %0d required 3", lat); end
        drive_req(1'b0, 32'd2, 32'd2, 1'b0);
        drive_req(1'b1, 32'd2, 32'd2, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (res_valid !== 1'b1 || res_lo !== 32'h0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold: got %0d bad cycles (v=%b lo=%h rdy=%b%b) required 0",
                               bad, res_valid, res_lo, r0_ready, r1_ready);
        end
        clear_req();
        e = sb.pop_front();
        checks++;
        if ({res_id, res_lo, res_hi} !== {e.id, e.lo, e.hi}) begin
            errors++; $display("FAIL stall_result: got id=%b lo=%h hi=%h required id=%b lo=%h hi=%h",
                               res_id, res_lo, res_hi, e.id, e.lo, e.hi);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b required 0", res_valid); end
    endtask

    task automatic test_reset_in_cap();
        exp_t e; int lat, men; logic [31:0] s1, s2, s3; int seen;
        @(negedge clk);
        drive_req(1'b0, 32'd9, 32'd9, 1'b0);
        sb.push_back(expect_op(1'b0, 32'd9, 32'd9, 1'b0));
        @(posedge clk);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, M_en, r0_ready, r1_ready, res_id} !== 5'b0 || res_lo !== 0 || res_hi !== 0 ||
            E_src1 !== 0 || E_src2 !== 0) begin
            errors++;
            $display("FAIL cap_reset_outputs: got v=%b men=%b rdy=%b%b id=%b lo=%h hi=%h s1=%h s2=%h required zero",
                     res_valid, M_en, r0_ready, r1_ready, res_id, res_lo, res_hi, E_src1, E_src2);
        end
        sb.delete();
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL cap_reset_no_result: got %0d valid cycles required 0", seen); end
        reset_n = 1'b1;
        drive_req(1'b0, 32'd7, 32'd6, 1'b0);
        #1;
        checks++;
        if (r0_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", r0_ready); end
        sb.push_back(expect_op(1'b0, 32'd7, 32'd6, 1'b0));
        @(posedge clk); #1; clear_req();
        wait_res(lat, men, s1, s2, s3);
        e = sb.pop_front();
        checks++;
        if (lat !== 3 || {res_id, res_lo, res_hi} !== {e.id, e.lo, e.hi}) begin
            errors++; $display("FAIL post_reset_result: got lat=%0d id=%b lo=%h hi=%h required lat=3 id=%b lo=%h hi=%h",
                               lat, res_id, res_lo, res_hi, e.id, e.lo, e.hi);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; res_ready = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0; r0_hi = 1'b0; r1_hi = 1'b0;
        test_reset();
        test_basic();
        test_hi_word();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_in_cap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
